// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one-outstanding-request fetcher feeding a DEPTH-entry queue.
// Optional same-cycle response bypass to dataF when FETCH_BUFFER_BYPASS_EN is defined.
package fetch_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_data_t;

endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       branch,
  input  logic [63:0]                jump,
  input  logic                       stop,
  output ibus_req_t                  ireq,
  input  ibus_resp_t                 iresp,
  output fetch_data_t                dataF,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mem [DEPTH];
  ptr_t        head, tail;
  cnt_t        count, count_next;
  logic [63:0] fetch_pc, fetch_pc_next, req_addr;
  logic        req_active, discard;
  logic        resp_ok, accept, bypass_hit, push, pop, issue;

  always_comb begin
    resp_ok = req_active & iresp.data_ok;
    // A response is kept only if no redirect has overtaken it.
    accept  = resp_ok & ~discard & ~branch;
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass_hit = accept & (count == '0);
`else
    bypass_hit = 1'b0;
`endif
    push = accept & ~(bypass_hit & ~stop);
    pop  = (count != '0) & ~branch & ~stop;

    if (branch)             count_next = '0;
    else if (push && !pop)  count_next = count + cnt_t'(1);
    else if (pop && !push)  count_next = count - cnt_t'(1);
    else                    count_next = count;

    if (branch)      fetch_pc_next = jump;
    else if (accept) fetch_pc_next = fetch_pc + 64'd4;
    else             fetch_pc_next = fetch_pc;

    // New request only once the bus is free, reserving a slot for its response.
    issue = (~req_active | resp_ok) & (count_next < cnt_t'(DEPTH));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      req_addr   <= '0;
      req_active <= 1'b0;
      discard    <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      fetch_pc   <= fetch_pc_next;
      count      <= count_next;
      req_active <= issue | (req_active & ~iresp.data_ok);
      if (issue) req_addr <= fetch_pc_next;
      if (resp_ok)                discard <= 1'b0;
      else if (branch && req_active) discard <= 1'b1;
      if (branch) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + ptr_t'(1);
        if (pop)  head <= head + ptr_t'(1);
      end
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: req_addr, instr: iresp.data};
  end

  // NOTE: dataF is defaulted before the conditional fills so no latch is inferred.
  always_comb begin
    ireq.valid = req_active;
    ireq.addr  = req_addr;
    dataF      = '0;
    if (count != '0) begin
      dataF.instr = mem[head].instr;
      dataF.pc    = mem[head].pc;
    end else if (bypass_hit) begin
      dataF.instr = iresp.data;
      dataF.pc    = req_addr;
    end
    dataF.valid = ((count != '0) | bypass_hit) & ~branch;
    occupancy   = count;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer; a small bus responder answers each
// request after a programmable number of wait cycles with data = ~addr[31:0].
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

`ifdef FETCH_BUFFER_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        branch;
  logic [63:0] jump;
  logic        stop;
  ibus_req_t   ireq;
  ibus_resp_t  iresp = '0;
  fetch_data_t dataF;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int wait_cnt = 0;

  fetch_buffer #(.DEPTH(4), .RESET_PC(64'h8000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .branch    (branch),
    .jump      (jump),
    .stop      (stop),
    .ireq      (ireq),
    .iresp     (iresp),
    .dataF     (dataF),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Bus responder: data_ok after 'lat' wait cycles of a held request.
  always @(posedge clk) begin
    #1;
    iresp.data_ok = 1'b0;
    if (reset || !ireq.valid) begin
      wait_cnt = 0;
    end else if (wait_cnt >= lat) begin
      iresp.data_ok = 1'b1;
      iresp.data    = ~ireq.addr[31:0];
      wait_cnt      = 0;
    end else begin
      wait_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    stop   = 1'b0;
    branch = 1'b0;
    jump   = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stop = 1'b0; branch = 1'b0; jump = '0;
    mid();
    check("rst ireq.valid", 64'(ireq.valid), 0);
    check("rst dataF.valid", 64'(dataF.valid), 0);
    check("rst dataF.instr", 64'(dataF.instr), 0);
    check("rst dataF.pc", dataF.pc, 0);
    check("rst occupancy", 64'(occupancy), 0);

    // Streaming fetch, zero wait states, no stall.
    lat = 0;
    do_reset();
    mid();
    check("s1 A ireq.valid", 64'(ireq.valid), 0);
    adv(); mid();
    check("s1 B ireq.valid", 64'(ireq.valid), 1);
    check("s1 B ireq.addr", ireq.addr, 64'h8000_0000);
    check("s1 B dataF.valid", 64'(dataF.valid), 64'(BYP));
    check("s1 B dataF.pc", dataF.pc, BYP ? 64'h8000_0000 : 64'h0);
    check("s1 B dataF.instr", 64'(dataF.instr), BYP ? 64'h7fff_ffff : 64'h0);
    adv(); mid();
    check("s1 C ireq.addr", ireq.addr, 64'h8000_0004);
    check("s1 C dataF.valid", 64'(dataF.valid), 1);
    check("s1 C dataF.pc", dataF.pc, BYP ? 64'h8000_0004 : 64'h8000_0000);
    check("s1 C occupancy", 64'(occupancy), BYP ? 64'd0 : 64'd1);
    adv(); mid();
    check("s1 D ireq.addr", ireq.addr, 64'h8000_0008);
    check("s1 D dataF.pc", dataF.pc, BYP ? 64'h8000_0008 : 64'h8000_0004);
    check("s1 D dataF.instr", 64'(dataF.instr), BYP ? 64'h7fff_fff7 : 64'h7fff_fffb);

    // Fill under stall, then drain in order.
    do_reset();
    stop = 1'b1;
    repeat (7) adv();
    mid();
    check("s2 full occupancy", 64'(occupancy), 4);
    check("s2 full ireq.valid", 64'(ireq.valid), 0);
    check("s2 full dataF.valid", 64'(dataF.valid), 1);
    check("s2 full dataF.pc", dataF.pc, 64'h8000_0000);
    adv(); stop = 1'b0; mid();
    check("s2 G dataF.pc", dataF.pc, 64'h8000_0000);
    check("s2 G occupancy", 64'(occupancy), 4);
    adv(); mid();
    check("s2 H dataF.pc", dataF.pc, 64'h8000_0004);
    check("s2 H ireq.valid", 64'(ireq.valid), 1);
    check("s2 H ireq.addr", ireq.addr, 64'h8000_0010);
    check("s2 H occupancy", 64'(occupancy), 3);
    adv(); mid();
    check("s2 I dataF.pc", dataF.pc, 64'h8000_0008);
    adv(); mid();
    check("s2 J dataF.pc", dataF.pc, 64'h8000_000c);

    // Branch with three queued entries, coinciding with a response.
    do_reset();
    stop = 1'b1;
    repeat (4) adv();
    branch = 1'b1; jump = 64'h8000_1000; lat = 1;
    mid();
    check("s3 E occupancy", 64'(occupancy), 3);
    check("s3 E dataF.valid", 64'(dataF.valid), 0);
    adv(); branch = 1'b0; mid();
    check("s3 F occupancy", 64'(occupancy), 0);
    check("s3 F dataF.valid", 64'(dataF.valid), 0);
    check("s3 F ireq.valid", 64'(ireq.valid), 1);
    check("s3 F ireq.addr", ireq.addr, 64'h8000_1000);
    adv(); mid();
    check("s3 G dataF.valid", 64'(dataF.valid), 64'(BYP));
    adv(); mid();
    check("s3 H dataF.valid", 64'(dataF.valid), 1);
    check("s3 H dataF.pc", dataF.pc, 64'h8000_1000);

    // Branch while a request is outstanding; its response is discarded.
    lat = 0;
    do_reset();
    repeat (4) adv();
    lat = 3;
    adv();
    branch = 1'b1; jump = 64'h8000_2000;
    mid();
    check("s4 F ireq.addr", ireq.addr, 64'h8000_0010);
    check("s4 F dataF.valid", 64'(dataF.valid), 0);
    adv(); branch = 1'b0; mid();
    check("s4 G occupancy", 64'(occupancy), 0);
    check("s4 G ireq.valid", 64'(ireq.valid), 1);
    check("s4 G ireq.addr", ireq.addr, 64'h8000_0010);
    adv(); mid();
    check("s4 H dataF.valid", 64'(dataF.valid), 0);
    adv(); mid();
    check("s4 I dataF.valid", 64'(dataF.valid), 0);
    check("s4 I ireq.addr", ireq.addr, 64'h8000_0010);
    adv(); lat = 0; mid();
    check("s4 J ireq.valid", 64'(ireq.valid), 1);
    check("s4 J ireq.addr", ireq.addr, 64'h8000_2000);
    check("s4 J occupancy", 64'(occupancy), 0);
    adv(); mid();
    check("s4 K dataF.valid", 64'(dataF.valid), 64'(BYP));
    adv(); mid();
    check("s4 L dataF.pc", dataF.pc, BYP ? 64'h8000_2004 : 64'h8000_2000);

    // Asynchronous reset in the middle of a request with two entries queued.
    lat = 1;
    do_reset();
    stop = 1'b1;
    repeat (5) adv();
    check("s5 pre occupancy", 64'(occupancy), 2);
    check("s5 pre ireq.valid", 64'(ireq.valid), 1);
    reset = 1'b1;
    #1;
    check("s5 rst ireq.valid", 64'(ireq.valid), 0);
    check("s5 rst dataF.valid", 64'(dataF.valid), 0);
    check("s5 rst dataF.instr", 64'(dataF.instr), 0);
    check("s5 rst dataF.pc", dataF.pc, 0);
    check("s5 rst occupancy", 64'(occupancy), 0);
    lat = 0;
    do_reset();
    mid();
    check("s5 A ireq.valid", 64'(ireq.valid), 0);
    adv(); mid();
    check("s5 B ireq.valid", 64'(ireq.valid), 1);
    check("s5 B ireq.addr", ireq.addr, 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port branch  input  1  redirect request; flushes the queue.
REQ-006 SHALL have port jump  input  64  redirect target, sampled when branch=1.
REQ-007 SHALL have port stop  input  1  downstream stall; head entry held.
REQ-008 SHALL have port ireq  output  ibus_req_t  instruction bus request (valid, addr).
REQ-009 SHALL have port iresp  input  ibus_resp_t  instruction bus response (data_ok, data).
REQ-010 SHALL have port dataF  output  fetch_data_t  head of queue to decode (valid, instr, pc).
REQ-011 SHALL have port occupancy  output  $clog2(DEPTH+1)  current queue entry count.

Function
REQ-012 SHALL keep a fetch PC; each accepted data_ok advances it by 4 (64-bit wrap, no overflow flag).
REQ-013 SHALL assert ireq.valid only when occupancy + inflight < DEPTH and no redirect is pending; at most one request outstanding.
REQ-014 SHALL hold ireq.addr and ireq.valid stable from assertion until the cycle iresp.data_ok=1.
REQ-015 SHALL, on data_ok with no discard flag, push {pc, iresp.data} at the tail one cycle later than data_ok-cycle sampling (registered write).
REQ-016 SHALL drive dataF.valid=1 whenever occupancy>0 and branch=0; dataF.instr/pc from the head entry, combinational from queue state.
REQ-017 SHALL pop the head when dataF.valid=1 and stop=0; simultaneous push and pop leaves occupancy unchanged.
REQ-018 SHALL, on branch=1: clear the queue (occupancy 0 next cycle), load fetch PC with jump; branch has priority over push, pop and stop.
REQ-019 SHALL, if branch=1 while a request is outstanding, set a discard flag, keep the old address on the bus until data_ok, drop that response, then issue at jump the following cycle.
REQ-020 SHALL, if branch and data_ok coincide, drop that response and issue at jump the next cycle.
REQ-021 SHALL, when full (occupancy=DEPTH), deassert ireq.valid; never overwrite the head.
REQ-022 SHALL use DEPTH-wrapping head/tail pointers of $clog2(DEPTH) bits plus a separate count.

Reset
REQ-023 SHALL, on reset assertion, asynchronously set fetch PC=RESET_PC, occupancy=0, pointers=0, discard=0, inflight=0, dataF.valid=0, dataF.instr=0, dataF.pc=0, ireq.valid=0.
REQ-024 SHALL, when reset asserts mid-request, abandon the request; the first post-reset request is to RESET_PC no earlier than one cycle after reset deasserts.

Configuration
REQ-025 SHALL support macro FETCH_BUFFER_BYPASS_EN.
REQ-026 SHALL, with FETCH_BUFFER_BYPASS_EN defined, present a non-discarded data_ok response directly on dataF in the same cycle when occupancy=0; if stop=0 it is consumed without enqueue, else enqueued.
REQ-027 SHALL, without FETCH_BUFFER_BYPASS_EN, deliver a response on dataF no earlier than the cycle after its data_ok.

Verification
REQ-028 SHALL cover: reset release, bus answers each request with 1-cycle data_ok, stop=0 -> ireq.addr 0x80000000, 0x80000004, 0x80000008 in order; dataF.pc follows same sequence.
REQ-029 SHALL cover: DEPTH=4, stop=1 throughout -> exactly 4 entries queued, occupancy=4, ireq.valid=0; release stop -> 4 pops in order, fetching resumes.
REQ-030 SHALL cover: branch=1, jump=0x80001000 with queue holding 3 entries -> occupancy 0 next cycle, dataF.valid=0, next issued addr 0x80001000.
REQ-031 SHALL cover: branch during outstanding request at 0x80000010, data_ok 3 cycles later -> that response never appears on dataF; next request addr = jump.
REQ-032 SHALL cover: reset asserted mid-request with occupancy=2 -> all outputs at reset values immediately, first request after release to 0x80000000.
REQ-033 SHALL cover: with FETCH_BUFFER_BYPASS_EN, empty queue, stop=0, data_ok for 0x80000000 -> dataF.valid=1, dataF.pc=0x80000000 in the data_ok cycle; without the macro, one cycle later.
